// File: rtl/boot_pkg.sv
// Shared types and constants for the MIPS program loader.
// BOOT_CHECKSUM_EN adds the trailing XOR checksum state.
package boot_pkg;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } boot_state_t;
`else
  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } boot_state_t;
`endif

  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx * BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid is
// asserted combinationally alongside the byte that completes a word.
module word_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [31:0] shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (byte_valid) begin
      cnt                       <= cnt + 2'd1;
      shreg[{cnt, 3'b000} +: 8] <= byte_data;
    end
  end

  // The completing byte bypasses the register so the word is ready on the accept edge.
  always_comb begin
    word_valid = byte_valid && (cnt == 2'(BYTES_PER_WORD - 1));
    word       = {byte_data, shreg[23:0]};
  end

endmodule

// File: rtl/boot_loader.sv
// Byte-stream program loader: writes N words to instruction memory and holds
// the core in reset until complete. BOOT_CHECKSUM_EN enables the XOR trailer.
module boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  boot_state_t state, state_nx;
  logic [7:0]  len_lo;
  logic [15:0] len16;
  logic [AW:0] n_words;
  logic [AW:0] w;
  logic        done_q;
  logic        done_set;
  logic        accept;
  logic        len_over;
  logic        len_zero;
  logic        last_word;
  logic        byte_valid;
  logic        word_valid;
  logic [31:0] word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_comb begin
    in_ready   = (state != S_DONE) && (state != S_ERR);
    accept     = in_valid && in_ready;
    len16      = {in_data, len_lo};
    len_zero   = (len16 == 16'd0);
    len_over   = (32'(len16) > 32'(DEPTH));
    last_word  = ((w + (AW+1)'(1)) == n_words);
    byte_valid = accept && (state == S_DATA);
  end

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (in_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    case (state)
      S_LEN_LO: if (accept) state_nx = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_over) begin
            state_nx = S_ERR;
          end else if (len_zero) begin
`ifdef BOOT_CHECKSUM_EN
            state_nx = S_CHK;
`else
            state_nx = S_DONE;
            done_set = 1'b1;
`endif
          end else begin
            state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_valid && last_word) begin
`ifdef BOOT_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DONE;
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (in_data == csum) begin
            state_nx = S_DONE;
            done_set = 1'b1;
          end else begin
            state_nx = S_ERR;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LEN_LO;
      len_lo     <= '0;
      n_words    <= '0;
      w          <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done_q     <= 1'b0;
    end else begin
      state   <= state_nx;
      imem_we <= word_valid;
      // Entering S_DONE from the payload defers done until after the final write.
      done_q  <= done_q || done_set || (state == S_DONE);
      if (accept && (state == S_LEN_LO)) len_lo <= in_data;
      if (accept && (state == S_LEN_HI)) n_words <= (AW+1)'(len16);
      if (word_valid) begin
        w          <= w + (AW+1)'(1);
        imem_addr  <= word_addr(32'(w));
        imem_wdata <= word;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum <= '0;
    else if (byte_valid) csum <= csum ^ in_data;
  end
`endif

  always_comb begin
    done      = done_q;
    core_hold = !done_q;
    error     = (state == S_ERR);
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Upstream program loader for the single-cycle MIPS core. It receives a byte stream over a valid/ready interface, packs the bytes into 32-bit words, and writes them sequentially into instruction memory starting at byte address 0. It holds the core in reset until the program image is complete, then releases it. It also reports completion or error.

## Interface
Parameters:
- DEPTH, 256, instruction memory capacity in words
- AW, 8, word-index width; must satisfy 2^AW >= DEPTH

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset; asynchronous, active-low
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  32  byte address, always word index × 4
- imem_wdata  output  32  packed word
- core_hold  output  1  high holds the core (drives datapath reset)
- done  output  1  image loaded successfully; sticky until reset
- error  output  1  image rejected; sticky until reset

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4×N payload bytes.
- Payload is little-endian per word: the first byte of each group goes to [7:0], the fourth to [31:24].
- A byte is accepted on a rising edge with in_valid & in_ready.
- FSM states: S_LEN_LO → S_LEN_HI → S_DATA → (S_CHK) → S_DONE, plus S_ERR.
- S_LEN_HI on accept:
  - N == 0 → S_DONE, or S_CHK when checksum is enabled.
  - N > DEPTH → S_ERR.
  - Otherwise → S_DATA.
- S_DATA:
  - A byte counter (0..3) fills the word register.
  - The 4th byte triggers a write of word index w, which then increments.
  - Acceptance of byte 4×N exits to S_DONE, or S_CHK when enabled.
- in_ready is 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CHK, and 0 in S_DONE and S_ERR.
- Bytes presented in S_DONE or S_ERR are ignored.
- core_hold = 1 in every state except S_DONE.
- S_ERR is terminal: core_hold stays 1 and error stays 1. Only rst exits S_DONE or S_ERR.
- in_valid may drop at any time. The FSM and counters simply stall; no timeout exists.

## Timing
- Reset values:
  - state = S_LEN_LO, in_ready = 1, core_hold = 1.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - done = 0, error = 0, all counters 0.
- Reset asserted mid-load aborts immediately. Partial memory contents are not cleared; the next image overwrites them from address 0.
- Write latency: imem_we is high for exactly one cycle, on the cycle after the 4th byte of a word is accepted. imem_addr and imem_wdata are registered and valid in that same cycle.
- Back-to-back bytes every cycle are supported, giving a maximum of one write per 4 cycles.
- Without checksum:
  - The last write occurs the cycle after the final byte.
  - done rises and core_hold falls one cycle after that final imem_we, so the core never fetches an unwritten word.
- N == 0 without checksum: done rises the cycle after LEN_HI is accepted.
- error rises the cycle after the offending byte is accepted.
- Word index w (AW+1 bits internally) never exceeds DEPTH, because length is checked before any write.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - One extra byte follows the payload: the XOR of all payload bytes (0x00 for N == 0).
  - It is accepted in S_CHK.
  - Match → S_DONE; the cycle after acceptance, done = 1 and core_hold = 0.
  - Mismatch → S_ERR; the cycle after acceptance, error = 1.
- BOOT_CHECKSUM_EN undefined: no S_CHK state and no XOR accumulator. Payload completion goes straight to S_DONE.

## Structure
- Shared package boot_pkg contains:
  - the state enum;
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4.
- Sub-module word_packer: a 2-bit byte counter plus a 32-bit shift/insert register. It emits word_valid and the packed word. The top-level FSM owns the length, address and checksum logic.

## Test plan
- Load N=2, bytes 02 00 | 20 08 00 05 | 00 00 00 08:
  - imem writes addr 0 = 0x05000820 and addr 4 = 0x08000000;
  - done = 1 and core_hold = 0 one cycle after the 2nd write;
  - error = 0.
- Same stream with in_valid toggling every other cycle → identical writes and final state, with longer latency.
- Header N=257 (01 01), DEPTH=256 → error = 1 the cycle after LEN_HI, no imem_we, in_ready = 0, core_hold stays 1.
- Assert rst after 6 payload bytes, then send a full N=1 image → a single write at addr 0 with the new word; done = 1.
- N=0 (00 00) → done the next cycle (with checksum: after byte 00); zero writes.
- BOOT_CHECKSUM_EN, N=1, payload 11 22 33 44:
  - checksum 0x44 → done = 1;
  - checksum 0x45 → error = 1 and core_hold stays 1.
